rps_match_controller: RTL and testbench
=======================================

# rps_match_controller

Round sequencer for the rock-paper-scissors game. It collects one move from each player per round, judges the round and drives the 2-bit `matchresult` code consumed by the score counters. It keeps its own round/win/lose tallies to detect match end (first to `WIN_TARGET` or `MAX_ROUNDS` played) and enforces a per-round move timeout with forfeit. It sits between the player input logic and the score/display path.

## Interface
- `WIN_TARGET`, 3: round wins that end the match (1..15)
- `MAX_ROUNDS`, 9: rounds (draws included) that end the match (1..15)
- `TIMEOUT`, 255: COLLECT cycles allowed per round before forfeit (1..65535, 16-bit timer)

- `clk`  in  1  single clock; all state updates on posedge
- `resetn`  in  1  asynchronous, active-high reset (despite the name); 1 forces reset immediately
- `start`  in  1  begin a new match; honoured only in IDLE or DONE
- `p1_valid`  in  1  player 1 move strobe
- `p1_move`  in  2  00 invalid, 01 rock, 10 paper, 11 scissors
- `p2_valid`  in  1  player 2 move strobe
- `p2_move`  in  2  same encoding
- `p1_ready`  out  1  high in COLLECT while the p1 move is not yet latched
- `p2_ready`  out  1  high in COLLECT while the p2 move is not yet latched
- `matchresult`  out  2  00 idle, 01 draw, 10 p1 wins, 11 p2 wins; non-zero only in RESULT
- `result_valid`  out  1  high exactly in RESULT
- `round`  out  4  rounds completed this match
- `win`  out  4  p1 round wins
- `lose`  out  4  p2 round wins
- `game_over`  out  1  high in DONE
- `champion`  out  2  00 none, 01 tie, 10 p1, 11 p2; valid in DONE, 00 otherwise
- `state`  out  3  debug: IDLE=0, COLLECT=1, JUDGE=2, RESULT=3, DONE=4

## Operation
- Reset: state IDLE. All outputs, tallies, latched moves and timer are 0.
- IDLE: `start` leads to COLLECT, clears tallies and timer.
- COLLECT: a move is latched when `pX_valid`=1, `pX_ready`=1 and `pX_move`≠00.
  - Invalid moves (00) and strobes after a move is latched are ignored.
  - Both players may be latched on the same edge.
  - Once both are latched, go to JUDGE.
  - Timer increments every COLLECT cycle. On the cycle it equals `TIMEOUT`-1 with a move still missing, go to JUDGE with the forfeit flag set.
  - A valid move arriving on the timeout cycle is latched and counts as submitted.
- JUDGE: compute the outcome into a register, then go to RESULT.
  - No forfeit: equal moves give 01. Paper beats rock, scissors beats paper, rock beats scissors; p1 victory gives 10, otherwise 11.
  - Forfeit: only p1 latched gives 10, only p2 latched gives 11, neither latched gives 01.
- RESULT: `matchresult` = outcome and `result_valid` = 1 for one cycle.
  - On the exit edge: `round`+1; `win`+1 on 10; `lose`+1 on 11. Latched moves and timer are cleared.
  - Then go to DONE if the new `win`=`WIN_TARGET`, or `lose`=`WIN_TARGET`, or `round`=`MAX_ROUNDS`; else COLLECT.
- DONE: `champion` is 10 if `win`>`lose`, 11 if `lose`>`win`, else 01. Tallies hold. `start` leads to COLLECT with tallies cleared.
- `start` in COLLECT/JUDGE/RESULT is ignored.
- Tallies never wrap: the end conditions stop the match at or before 15.

## Timing
- All outputs are registered or decoded from the registered state and tallies only. No input-to-output combinational path.
- Second move accepted at edge k: JUDGE during cycle k..k+1, RESULT during k+1..k+2, counters updated at edge k+2, next state (COLLECT or DONE) from k+2.
- Minimum round length is 3 cycles (COLLECT, JUDGE, RESULT).
- `pX_ready` falls the cycle after that player's move is latched.
- Timeout: COLLECT entered at edge s with no moves gives JUDGE after edge s+`TIMEOUT`.
- `matchresult` is 00 in every non-RESULT cycle, so downstream gated counters advance only on real results.
- Reset asserted mid-round (any state) returns to IDLE asynchronously. Outputs go to 0 without waiting for `clk`. The in-flight round is discarded.

## Test plan
- Reset, `start`, p1 paper (10) and p2 rock (01) on the same edge -> JUDGE next cycle, then one RESULT cycle with `matchresult`=10; after it `win`=1, `round`=1, state COLLECT.
- p1 rock then p2 rock three cycles later; p1 re-strobes scissors in between -> re-strobe ignored, `matchresult`=01, `round`=1, `win`=`lose`=0.
- `TIMEOUT`=4, only p2 submits scissors -> JUDGE exactly 4 cycles after COLLECT entry, `matchresult`=11. Repeat with no moves -> 01.
- Default parameters, p2 wins 3 consecutive rounds -> DONE, `game_over`=1, `champion`=11, `lose`=3, `round`=3. `start` -> tallies 0, COLLECT.
- `MAX_ROUNDS`=2, one p1 win and one p2 win -> DONE after round 2 with `champion`=01.
- Reset pulse during JUDGE after a p1 win is pending -> state IDLE immediately, `matchresult`=00, `win`=0. `p1_move`=00 with `p1_valid` in COLLECT -> `p1_ready` stays 1.

Source files
------------

// File: rtl/rps_match_controller.sv
// Rock-paper-scissors round sequencer: collects one move per player per round,
// judges it, reports a one-cycle result code and tracks the match tallies until
// a player reaches WIN_TARGET round wins or MAX_ROUNDS rounds have been played.
// The reset input is named resetn but is asynchronous and active-high.
module rps_match_controller #(
  parameter int WIN_TARGET = 3,
  parameter int MAX_ROUNDS = 9,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       p1_valid,
  input  logic [1:0] p1_move,
  input  logic       p2_valid,
  input  logic [1:0] p2_move,
  output logic       p1_ready,
  output logic       p2_ready,
  output logic [1:0] matchresult,
  output logic       result_valid,
  output logic [3:0] round,
  output logic [3:0] win,
  output logic [3:0] lose,
  output logic       game_over,
  output logic [1:0] champion,
  output logic [2:0] state
);

  localparam logic [3:0]  WIN_LIMIT   = 4'(WIN_TARGET);
  localparam logic [3:0]  ROUND_LIMIT = 4'(MAX_ROUNDS);
  localparam logic [15:0] TIMER_LAST  = 16'(TIMEOUT - 1);

  localparam logic [1:0] ROCK     = 2'b01;
  localparam logic [1:0] PAPER    = 2'b10;
  localparam logic [1:0] SCISSORS = 2'b11;

  localparam logic [1:0] RES_IDLE = 2'b00;
  localparam logic [1:0] RES_DRAW = 2'b01;
  localparam logic [1:0] RES_P1   = 2'b10;
  localparam logic [1:0] RES_P2   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_JUDGE   = 3'd2,
    S_RESULT  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t      state_q;
  logic [1:0]  p1_move_q, p2_move_q;
  logic        p1_have, p2_have;
  logic [15:0] timer_q;

  logic        p1_take, p2_take;
  logic        p1_have_next, p2_have_next;
  logic [1:0]  outcome;
  logic [3:0]  round_inc, win_inc, lose_inc;
  logic        match_end;
  logic [1:0]  champion_next;

  assign state    = state_q;
  assign p1_ready = (state_q == S_COLLECT) && !p1_have;
  assign p2_ready = (state_q == S_COLLECT) && !p2_have;

  // Move acceptance: a strobe counts only while that player is still waiting and the move is real.
  always_comb begin
    p1_take      = p1_valid && p1_ready && (p1_move != 2'b00);
    p2_take      = p2_valid && p2_ready && (p2_move != 2'b00);
    p1_have_next = p1_have || p1_take;
    p2_have_next = p2_have || p2_take;
  end

  // Round judgement from the latched moves; a missing move forfeits the round.
  always_comb begin
    // NOTE: default assignment first, so no path through this block can infer a latch.
    outcome = RES_DRAW;
    if (p1_have && p2_have) begin
      if (p1_move_q == p2_move_q) begin
        outcome = RES_DRAW;
      end else if ((p1_move_q == PAPER    && p2_move_q == ROCK)  ||
                   (p1_move_q == SCISSORS && p2_move_q == PAPER) ||
                   (p1_move_q == ROCK     && p2_move_q == SCISSORS)) begin
        outcome = RES_P1;
      end else begin
        outcome = RES_P2;
      end
    end else if (p1_have) begin
      outcome = RES_P1;
    end else if (p2_have) begin
      outcome = RES_P2;
    end
  end

  // Post-round tallies and the match-end decision taken on the RESULT exit edge.
  always_comb begin
    round_inc = round + 4'd1;
    win_inc   = win  + {3'b000, matchresult == RES_P1};
    lose_inc  = lose + {3'b000, matchresult == RES_P2};
    match_end = (win_inc == WIN_LIMIT) || (lose_inc == WIN_LIMIT) || (round_inc == ROUND_LIMIT);
    if (win_inc > lose_inc)      champion_next = RES_P1;
    else if (lose_inc > win_inc) champion_next = RES_P2;
    else                         champion_next = RES_DRAW;
  end

  // Match sequencer with registered result, tally and champion outputs.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
      state_q      <= S_IDLE;
      p1_move_q    <= 2'b00;
      p2_move_q    <= 2'b00;
      p1_have      <= 1'b0;
      p2_have      <= 1'b0;
      timer_q      <= 16'd0;
      matchresult  <= RES_IDLE;
      result_valid <= 1'b0;
      round        <= 4'd0;
      win          <= 4'd0;
      lose         <= 4'd0;
      game_over    <= 1'b0;
      champion     <= RES_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q   <= S_COLLECT;
            round     <= 4'd0;
            win       <= 4'd0;
            lose      <= 4'd0;
            timer_q   <= 16'd0;
            p1_have   <= 1'b0;
            p2_have   <= 1'b0;
            game_over <= 1'b0;
            champion  <= RES_IDLE;
          end
        end
        S_COLLECT: begin
          if (p1_take) begin
            p1_move_q <= p1_move;
            p1_have   <= 1'b1;
          end
          if (p2_take) begin
            p2_move_q <= p2_move;
            p2_have   <= 1'b1;
          end
          timer_q <= timer_q + 16'd1;
          if ((p1_have_next && p2_have_next) || (timer_q == TIMER_LAST)) begin
            state_q <= S_JUDGE;
          end
        end
        S_JUDGE: begin
          matchresult  <= outcome;
          result_valid <= 1'b1;
          state_q      <= S_RESULT;
        end
        S_RESULT: begin
          matchresult  <= RES_IDLE;
          result_valid <= 1'b0;
          round        <= round_inc;
          win          <= win_inc;
          lose         <= lose_inc;
          p1_move_q    <= 2'b00;
          p2_move_q    <= 2'b00;
          p1_have      <= 1'b0;
          p2_have      <= 1'b0;
          timer_q      <= 16'd0;
          if (match_end) begin
            state_q   <= S_DONE;
            game_over <= 1'b1;
            champion  <= champion_next;
          end else begin
            state_q <= S_COLLECT;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rps_match_controller.sv
// Self-checking bench for rps_match_controller: directed rounds plus randomized
// rounds judged by a round-level behavioural model.
module tb_rps_match_controller;

  localparam int WT  = 3;
  localparam int MR  = 4;
  localparam int TMO = 5;
  localparam int NC  = 8;

  logic       clk, resetn, start;
  logic       p1_valid, p2_valid;
  logic [1:0] p1_move, p2_move;
  logic       p1_ready, p2_ready, result_valid, game_over;
  logic [1:0] matchresult, champion;
  logic [3:0] round, win, lose;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;
  int m_round, m_win, m_lose;

  // Per-round stimulus table, one entry per COLLECT cycle.
  logic       sv1[NC], sv2[NC], sst[NC];
  logic [1:0] sm1[NC], sm2[NC];

  rps_match_controller #(.WIN_TARGET(WT), .MAX_ROUNDS(MR), .TIMEOUT(TMO)) u_dut (
    .clk(clk), .resetn(resetn), .start(start),
    .p1_valid(p1_valid), .p1_move(p1_move),
    .p2_valid(p2_valid), .p2_move(p2_move),
    .p1_ready(p1_ready), .p2_ready(p2_ready),
    .matchresult(matchresult), .result_valid(result_valid),
    .round(round), .win(win), .lose(lose),
    .game_over(game_over), .champion(champion), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; p1_valid = 0; p2_valid = 0; p1_move = 2'b00; p2_move = 2'b00;
  endtask

  task automatic clear_round();
    for (int i = 0; i < NC; i++) begin
      sv1[i] = 0; sv2[i] = 0; sst[i] = 0; sm1[i] = 2'b00; sm2[i] = 2'b00;
    end
  endtask

  task automatic rand_round();
    for (int i = 0; i < NC; i++) begin
      sv1[i] = ($urandom_range(0, 2) == 0);
      sv2[i] = ($urandom_range(0, 2) == 0);
      sm1[i] = 2'($urandom_range(0, 3));
      sm2[i] = 2'($urandom_range(0, 3));
      sst[i] = ($urandom_range(0, 7) == 0);
    end
  endtask

  // Rock=1, paper=2, scissors=3: the winner is the move one step ahead modulo 3.
  function automatic int judge(int a, int b, bit h1, bit h2);
    if (h1 && h2) begin
      case ((a - b + 3) % 3)
        0:       return 1;
        1:       return 2;
        default: return 3;
      endcase
    end
    if (h1) return 2;
    if (h2) return 3;
    return 1;
  endfunction

  function automatic int champ_of(int w, int l);
    if (w > l) return 2;
    if (l > w) return 3;
    return 1;
  endfunction

  task automatic start_match();
    start = 1;
    tick();
    start = 0;
    m_round = 0; m_win = 0; m_lose = 0;
    check("start_state", state, 1);
    check("start_round", round, 0);
    check("start_win", win, 0);
    check("start_lose", lose, 0);
    check("start_game_over", game_over, 0);
  endtask

  // Play one round from the first COLLECT cycle; the model predicts acceptance,
  // round length, outcome and the tallies afterwards.
  task automatic play_round(output bit done);
    int c1, c2, e, a, b, exp_res;
    c1 = -1; c2 = -1; a = 0; b = 0;
    for (int i = 0; i < TMO && i < NC; i++) begin
      if (c1 < 0 && sv1[i] && sm1[i] != 2'b00) begin c1 = i; a = int'(sm1[i]); end
      if (c2 < 0 && sv2[i] && sm2[i] != 2'b00) begin c2 = i; b = int'(sm2[i]); end
    end
    if (c1 >= 0 && c2 >= 0) e = (c1 > c2) ? c1 : c2;
    else                    e = TMO - 1;
    exp_res = judge(a, b, c1 >= 0, c2 >= 0);

    for (int i = 0; i <= e; i++) begin
      check("collect_state", state, 1);
      check("p1_ready", p1_ready, !(c1 >= 0 && c1 < i));
      check("p2_ready", p2_ready, !(c2 >= 0 && c2 < i));
      check("idle_result", matchresult, 0);
      p1_valid = sv1[i]; p1_move = sm1[i];
      p2_valid = sv2[i]; p2_move = sm2[i];
      start    = sst[i];
      tick();
    end
    idle_inputs();
    check("judge_state", state, 2);
    check("judge_result", matchresult, 0);
    check("judge_valid", result_valid, 0);
    tick();
    check("result_state", state, 3);
    check("matchresult", matchresult, exp_res);
    check("result_valid", result_valid, 1);
    tick();
    m_round++;
    if (exp_res == 2) m_win++;
    if (exp_res == 3) m_lose++;
    done = (m_win == WT) || (m_lose == WT) || (m_round == MR);
    check("round", round, m_round);
    check("win", win, m_win);
    check("lose", lose, m_lose);
    check("post_state", state, done ? 4 : 1);
    check("post_result", matchresult, 0);
    check("game_over", game_over, done);
    check("champion", champion, done ? champ_of(m_win, m_lose) : 0);
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear without a clock.
  task automatic async_reset(input string tag);
    #2 resetn = 1;
    #1;
    check({tag, "_state"}, state, 0);
    check({tag, "_matchresult"}, matchresult, 0);
    check({tag, "_result_valid"}, result_valid, 0);
    check({tag, "_win"}, win, 0);
    check({tag, "_round"}, round, 0);
    #1 resetn = 0;
    m_round = 0; m_win = 0; m_lose = 0;
  endtask

  initial begin
    bit done;
    idle_inputs();
    clear_round();
    resetn = 1;
    #22 resetn = 0;
    tick();

    check("rst_state", state, 0);
    check("rst_matchresult", matchresult, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_round", round, 0);
    check("rst_game_over", game_over, 0);
    check("rst_champion", champion, 0);
    check("rst_p1_ready", p1_ready, 0);
    check("rst_p2_ready", p2_ready, 0);
    start_match();

    // Paper beats rock, both moves on the same edge.
    clear_round();
    sv1[0] = 1; sm1[0] = 2'b10; sv2[0] = 1; sm2[0] = 2'b01;
    play_round(done);

    // Rock vs rock with a p1 re-strobe and an ignored start in between.
    clear_round();
    sv1[0] = 1; sm1[0] = 2'b01;
    sv1[1] = 1; sm1[1] = 2'b11;
    sst[2] = 1;
    sv2[3] = 1; sm2[3] = 2'b01;
    play_round(done);

    // Timeout with only p2 submitting; p1 strobes invalid moves.
    clear_round();
    sv1[0] = 1; sm1[0] = 2'b00;
    sv2[1] = 1; sm2[1] = 2'b11;
    sv1[2] = 1; sm1[2] = 2'b00;
    play_round(done);

    // Timeout with no moves: draw, and the round limit ends the match as a tie.
    clear_round();
    play_round(done);
    check("maxrounds_done", done, 1);
    start_match();

    // p2 wins three rounds in a row.
    for (int r = 0; r < 3; r++) begin
      clear_round();
      sv1[0] = 1; sm1[0] = 2'b01;
      sv2[r] = 1; sm2[r] = 2'b10;
      play_round(done);
    end
    check("p2_match_done", done, 1);
    start_match();

    // Randomized rounds, restarting whenever a match finishes.
    for (int r = 0; r < 40; r++) begin
      rand_round();
      play_round(done);
      if (done) start_match();
    end

    // Reset in the middle of a round, then reset while a p1 win sits in JUDGE.
    async_reset("rst_mid");
    tick();
    start_match();
    clear_round();
    sv1[0] = 1; sm1[0] = 2'b10; sv2[0] = 1; sm2[0] = 2'b01;
    play_round(done);
    check("pre_reset_win", win, 1);
    p1_valid = 1; p1_move = 2'b11; p2_valid = 1; p2_move = 2'b10;
    tick();
    idle_inputs();
    check("pre_reset_judge", state, 2);
    async_reset("rst_judge");
    tick();
    check("post_reset_idle", state, 0);
    check("post_reset_p1_ready", p1_ready, 0);
    tick();
    check("post_reset_matchresult", matchresult, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
